// File: rtl/req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module   : req_ack_responder
// Function : Responder side of the single-cycle req/ack pulse protocol with
//            fixed ack latency, minimum-spacing enforcement and status counters.
// Revision : 1.0
// ============================================================================
module req_ack_responder #(
    parameter int unsigned ACK_LATENCY = 4,
    parameter int unsigned MIN_GAP     = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             err_clr,
    output logic             ack,
    output logic             busy,
    output logic             gap_err,
    output logic [CNT_W-1:0] req_count,
    output logic [CNT_W-1:0] ack_count
);

    localparam int unsigned          c_GAP_W    = $clog2(MIN_GAP);
    localparam logic [c_GAP_W-1:0]   c_GAP_INIT = c_GAP_W'(MIN_GAP - 1);
    localparam logic [3:0]           c_LAT_INIT = 4'(ACK_LATENCY - 1);
    localparam bit                   c_LAT_ONE  = (ACK_LATENCY == 1);

    // r_gap == 0 means the spacing since the last accepted req is satisfied.
    logic [c_GAP_W-1:0] r_gap;
    logic [3:0]         r_lat;
    logic               w_accept;
    logic               w_violation;
    logic               w_ack_next;

    always_comb begin
        w_accept    = req && (r_gap == '0);
        w_violation = req && !w_accept;
        // ack is registered, so it is loaded one edge before it is sampled high.
        w_ack_next  = (w_accept && c_LAT_ONE) || (r_lat == 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap     <= '0;
            r_lat     <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            gap_err   <= 1'b0;
            req_count <= '0;
            ack_count <= '0;
        end else begin
            if (w_accept) begin
                r_gap <= c_GAP_INIT;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - c_GAP_W'(1);
            end

            if (w_accept) begin
                r_lat <= c_LAT_INIT;
            end else if (r_lat != 4'd0) begin
                r_lat <= r_lat - 4'd1;
            end

            ack <= w_ack_next;

            if (w_accept) begin
                busy <= 1'b1;
            end else if (ack) begin
                busy <= 1'b0;
            end

            if (w_violation) begin
                gap_err <= 1'b1;
            end else if (err_clr) begin
                gap_err <= 1'b0;
            end

            if (w_accept) begin
                req_count <= req_count + CNT_W'(1);
            end
            if (ack) begin
                ack_count <= ack_count + CNT_W'(1);
            end
        end
    end

`ifdef FORMAL
    a_ack_after_accept : assert property (@(posedge clk) disable iff (!rst_n)
        w_accept |-> ##ACK_LATENCY ack);
    a_no_spurious_ack : assert property (@(posedge clk) disable iff (!rst_n)
        !$past(w_accept, ACK_LATENCY) |-> !ack);
    a_ack_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
        ack |=> !ack);
    a_count_order : assert property (@(posedge clk) disable iff (!rst_n)
        (req_count < {CNT_W{1'b1}}) |-> (ack_count <= req_count));
    c_two_busy : cover property (@(posedge clk) req_count == CNT_W'(2) && busy);
    c_second_ack : cover property (@(posedge clk) ack && ack_count == CNT_W'(1));
    c_gap_err : cover property (@(posedge clk) $rose(gap_err));
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_ack_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_ack_responder
// Function : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a timestamp-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_req_ack_responder;

    localparam int c_L = 4;
    localparam int c_G = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       err_clr = 1'b0;
    logic       ack, busy, gap_err;
    logic [7:0] req_count, ack_count;
    logic       ack2, busy2, gap_err2;
    logic [1:0] req_count2, ack_count2;

    req_ack_responder #(.ACK_LATENCY(c_L), .MIN_GAP(c_G), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .err_clr(err_clr),
        .ack(ack), .busy(busy), .gap_err(gap_err),
        .req_count(req_count), .ack_count(ack_count)
    );

    req_ack_responder #(.ACK_LATENCY(c_L), .MIN_GAP(c_G), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .err_clr(err_clr),
        .ack(ack2), .busy(busy2), .gap_err(gap_err2),
        .req_count(req_count2), .ack_count(ack_count2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edge index, last accepted edge, queue of unacked accept edges.
    int n = 0;
    int last_acc = -1000;
    int pend[$];
    int m_rc = 0;
    int m_ac = 0;
    bit m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, n, got, exp);
        end
    endtask

    task automatic model_reset();
        last_acc = -1000;
        pend.delete();
        m_rc  = 0;
        m_ac  = 0;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic c);
        bit acc;
        n++;
        acc = r && (n - last_acc >= c_G);
        if (pend.size() > 0 && pend[0] + c_L == n) begin
            void'(pend.pop_front());
            m_ac++;
        end
        if (acc) begin
            last_acc = n;
            m_rc++;
            pend.push_back(n);
        end
        if (r && !acc) m_err = 1'b1;
        else if (c)    m_err = 1'b0;
    endtask

    task automatic check_model();
        logic e_ack;
        logic e_busy;
        e_ack  = (pend.size() > 0) && (pend[0] + c_L == n + 1);
        e_busy = (pend.size() > 0);
        chk("ack", ack, e_ack);
        chk("busy", busy, e_busy);
        chk("gap_err", gap_err, m_err);
        chk("req_count", req_count, m_rc & 255);
        chk("ack_count", ack_count, m_ac & 255);
        chk("ack_w2", ack2, e_ack);
        chk("busy_w2", busy2, e_busy);
        chk("gap_err_w2", gap_err2, m_err);
        chk("req_count_w2", req_count2, m_rc & 3);
        chk("ack_count_w2", ack_count2, m_ac & 3);
    endtask

    task automatic step(input logic r, input logic c);
        req     = r;
        err_clr = c;
        @(posedge clk);
        model_edge(r, c);
        #1;
        check_model();
        req     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_gap_err"}, gap_err, 0);
        chk({tag, "_req_count"}, req_count, 0);
        chk({tag, "_ack_count"}, ack_count, 0);
    endtask

    // Next posedge after return is edge 1.
    task automatic do_reset();
        req     = 1'b0;
        err_clr = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int   idle;
        logic r;
        logic c;
        logic e_ack;
        logic e_busy;
        logic e_err;
        int   e_rc;
        int   e_ac;
    } vec_t;

    vec_t       tbl[15];
    logic [1:0] seq6[5];

    initial begin
        // Each row: idle edges, then one edge with (req, err_clr), then outputs after it.
        tbl[0]  = '{9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};  // edge 10 accepted
        tbl[1]  = '{2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 0};  // edge 13 gap 3 rejected
        tbl[2]  = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};  // edge 14 ack sampled
        tbl[3]  = '{3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1};  // edge 18 gap 8 from 10
        tbl[4]  = '{2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1};  // edge 21
        tbl[5]  = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2};  // edge 22 ack sampled
        tbl[6]  = '{7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2};  // edge 30 err_clr
        tbl[7]  = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 2};  // edge 31 accepted
        tbl[8]  = '{0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3, 2};  // edge 32 set beats clear
        tbl[9]  = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2};  // edge 33 long req
        tbl[10] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 2};  // edge 34
        tbl[11] = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3};  // edge 35 ack sampled
        tbl[12] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3};  // edge 36 err_clr
        tbl[13] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 3};  // edge 38 gap 7 rejected
        tbl[14] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4, 3};  // edge 39 gap 8 accepted
        seq6[0] = 2'd1; seq6[1] = 2'd2; seq6[2] = 2'd3; seq6[3] = 2'd0; seq6[4] = 2'd1;

        #2;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            repeat (tbl[i].idle) step(1'b0, 1'b0);
            step(tbl[i].r, tbl[i].c);
            chk($sformatf("vec%0d_ack", i), ack, tbl[i].e_ack);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("vec%0d_gap_err", i), gap_err, tbl[i].e_err);
            chk($sformatf("vec%0d_req_count", i), req_count, tbl[i].e_rc);
            chk($sformatf("vec%0d_ack_count", i), ack_count, tbl[i].e_ac);
        end

        // Reset while an ack is in flight: it must never appear.
        do_reset();
        repeat (9) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            chk("midrst_no_ack", ack, 0);
        end
        step(1'b1, 1'b0);
        chk("midrst_req_accepted", req_count, 1);
        chk("midrst_busy", busy, 1);

        // Narrow counters wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0);
            chk($sformatf("wrap_req_count_%0d", i), req_count2, seq6[i]);
            repeat (7) step(1'b0, 1'b0);
        end
        chk("wrap_final_req_count", req_count2, 1);
        chk("wrap_final_ack_count", ack_count2, 1);

        // Random traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
